// File: rtl/minmax_pkg.sv
// Shared types and constants for the streaming min/max tracker.
package minmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int          DATA_W    = 32;
  localparam logic [31:0] SIGN_FLIP = 32'h8000_0000;

endpackage

// File: rtl/compare32bit.sv
// Unsigned 32-bit magnitude comparator producing one-hot greater/equal/less flags.
module compare32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        AgtB,
  output logic        AeqB,
  output logic        AltB
);

  assign AgtB = (a > b);
  assign AeqB = (a == b);
  assign AltB = (a < b);

endmodule

// File: rtl/minmax_tracker.sv
// Frame-based min/max tracker: accumulates min, max, their first positions and a
// saturating sample count, then holds the result until the consumer takes it.
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter bit SIGNED = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [CNT_W-1:0]  out_min_idx,
  output logic [CNT_W-1:0]  out_max_idx,
  output logic [CNT_W-1:0]  out_count
);

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [DATA_W-1:0] FLIP = SIGNED ? SIGN_FLIP : '0;

  state_t state, state_next;

  logic [DATA_W-1:0] min_q, max_q;
  logic [CNT_W-1:0]  min_idx_q, max_idx_q, count_q;
  logic [CNT_W-1:0]  count_inc;
  logic              accept;

  logic [DATA_W-1:0] data_cmp, min_cmp, max_cmp;
  logic              data_lt_min, data_gt_max;
  logic              min_gt_unused, min_eq_unused;
  logic              max_eq_unused, max_lt_unused;

  assign data_cmp = in_data ^ FLIP;
  assign min_cmp  = min_q ^ FLIP;
  assign max_cmp  = max_q ^ FLIP;

  compare32bit u_cmp_min (
    .a    (data_cmp),
    .b    (min_cmp),
    .AgtB (min_gt_unused),
    .AeqB (min_eq_unused),
    .AltB (data_lt_min)
  );

  compare32bit u_cmp_max (
    .a    (data_cmp),
    .b    (max_cmp),
    .AgtB (data_gt_max),
    .AeqB (max_eq_unused),
    .AltB (max_lt_unused)
  );

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: next-state defaults to the current state first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = in_last ? HOLD : ACCUM;
      ACCUM:   if (accept && in_last) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
      count_q   <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        min_q     <= in_data;
        max_q     <= in_data;
        min_idx_q <= '0;
        max_idx_q <= '0;
        count_q   <= CNT_W'(1);
      end else begin
        // Strict compares: ties keep the first occurrence.
        if (data_lt_min) begin
          min_q     <= in_data;
          min_idx_q <= count_q;
        end
        if (data_gt_max) begin
          max_q     <= in_data;
          max_idx_q <= count_q;
        end
        count_q <= count_inc;
      end
    end
  end

  assign out_min     = min_q;
  assign out_max     = max_q;
  assign out_min_idx = min_idx_q;
  assign out_max_idx = max_idx_q;
  assign out_count   = count_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench: three tracker instances (unsigned, signed, 3-bit count) share
// one input stream; each frame result is compared against hand-computed values.
module tb_minmax_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_u, out_valid_u;
  logic [31:0] min_u, max_u;
  logic [15:0] min_idx_u, max_idx_u, count_u;

  logic        in_ready_s, out_valid_s;
  logic [31:0] min_s, max_s;
  logic [15:0] min_idx_s, max_idx_s, count_s;

  logic        in_ready_c, out_valid_c;
  logic [31:0] min_c, max_c;
  logic [2:0]  min_idx_c, max_idx_c, count_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minmax_tracker #(.SIGNED(1'b0), .CNT_W(16)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_min(min_u), .out_max(max_u),
    .out_min_idx(min_idx_u), .out_max_idx(max_idx_u), .out_count(count_u)
  );

  minmax_tracker #(.SIGNED(1'b1), .CNT_W(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_min(min_s), .out_max(max_s),
    .out_min_idx(min_idx_s), .out_max_idx(max_idx_s), .out_count(count_s)
  );

  minmax_tracker #(.SIGNED(1'b0), .CNT_W(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_c),
    .out_ready(out_ready), .out_min(min_c), .out_max(max_c),
    .out_min_idx(min_idx_c), .out_max_idx(max_idx_c), .out_count(count_c)
  );

  typedef struct {
    int          len;
    logic [31:0] data [0:9];
    logic [31:0] umin, umax;
    int          umin_i, umax_i;
    logic [31:0] smin, smax;
    int          smin_i, smax_i;
    int          cnt;
  } vec_t;

  vec_t vecs [0:4];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic int sat7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  // Presents one beat at the falling edge; it is accepted at the next rising edge.
  task automatic beat(input logic [31:0] d, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_hs_out_valid", 32'(out_valid_u), 32'd0);
    check("post_hs_in_ready", 32'(in_ready_u), 32'd1);
  endtask

  task automatic set_vec(input int k, input int len, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3, input logic [31:0] d4);
    vecs[k].len = len;
    vecs[k].cnt = len;
    vecs[k].data[0] = d0; vecs[k].data[1] = d1; vecs[k].data[2] = d2;
    vecs[k].data[3] = d3; vecs[k].data[4] = d4;
    for (int i = 5; i < 10; i++) vecs[k].data[i] = '0;
  endtask

  initial begin
    set_vec(0, 1, 32'd5, 0, 0, 0, 0);
    vecs[0].umin = 32'd5; vecs[0].umax = 32'd5; vecs[0].umin_i = 0; vecs[0].umax_i = 0;
    vecs[0].smin = 32'd5; vecs[0].smax = 32'd5; vecs[0].smin_i = 0; vecs[0].smax_i = 0;

    set_vec(1, 5, 32'd7, 32'd3, 32'd9, 32'd3, 32'd9);
    vecs[1].umin = 32'd3; vecs[1].umax = 32'd9; vecs[1].umin_i = 1; vecs[1].umax_i = 2;
    vecs[1].smin = 32'd3; vecs[1].smax = 32'd9; vecs[1].smin_i = 1; vecs[1].smax_i = 2;

    set_vec(2, 2, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0);
    vecs[2].umin = 32'h1;         vecs[2].umax = 32'hFFFF_FFFF; vecs[2].umin_i = 0; vecs[2].umax_i = 1;
    vecs[2].smin = 32'hFFFF_FFFF; vecs[2].smax = 32'h1;         vecs[2].smin_i = 1; vecs[2].smax_i = 0;

    set_vec(3, 10, 32'd10, 32'd20, 32'd30, 32'd40, 32'd50);
    vecs[3].data[5] = 32'd5;  vecs[3].data[6] = 32'd60; vecs[3].data[7] = 32'd70;
    vecs[3].data[8] = 32'd80; vecs[3].data[9] = 32'd100;
    vecs[3].umin = 32'd5; vecs[3].umax = 32'd100; vecs[3].umin_i = 5; vecs[3].umax_i = 9;
    vecs[3].smin = 32'd5; vecs[3].smax = 32'd100; vecs[3].smin_i = 5; vecs[3].smax_i = 9;

    set_vec(4, 3, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 0, 0);
    vecs[4].umin = 32'h0;         vecs[4].umax = 32'h8000_0000; vecs[4].umin_i = 2; vecs[4].umax_i = 0;
    vecs[4].smin = 32'h8000_0000; vecs[4].smax = 32'h7FFF_FFFF; vecs[4].smin_i = 0; vecs[4].smax_i = 1;

    // Reset state.
    #12;
    check("rst_out_valid", 32'(out_valid_u), 32'd0);
    check("rst_count", 32'(count_u), 32'd0);
    check("rst_min", min_u, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready_u), 32'd1);

    // Table-driven frames.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < vecs[k].len; i++) begin
        beat(vecs[k].data[i], i == vecs[k].len - 1);
        if (i != vecs[k].len - 1) check($sformatf("v%0d_mid_valid", k), 32'(out_valid_u), 32'd0);
      end
      @(negedge clk);
      check($sformatf("v%0d_u_valid", k), 32'(out_valid_u), 32'd1);
      check($sformatf("v%0d_u_ready", k), 32'(in_ready_u), 32'd0);
      check($sformatf("v%0d_u_min", k), min_u, vecs[k].umin);
      check($sformatf("v%0d_u_max", k), max_u, vecs[k].umax);
      check($sformatf("v%0d_u_min_idx", k), 32'(min_idx_u), 32'(vecs[k].umin_i));
      check($sformatf("v%0d_u_max_idx", k), 32'(max_idx_u), 32'(vecs[k].umax_i));
      check($sformatf("v%0d_u_count", k), 32'(count_u), 32'(vecs[k].cnt));
      check($sformatf("v%0d_s_min", k), min_s, vecs[k].smin);
      check($sformatf("v%0d_s_max", k), max_s, vecs[k].smax);
      check($sformatf("v%0d_s_min_idx", k), 32'(min_idx_s), 32'(vecs[k].smin_i));
      check($sformatf("v%0d_s_max_idx", k), 32'(max_idx_s), 32'(vecs[k].smax_i));
      check($sformatf("v%0d_c_max", k), max_c, vecs[k].umax);
      check($sformatf("v%0d_c_min_idx", k), 32'(min_idx_c), 32'(sat7(vecs[k].umin_i)));
      check($sformatf("v%0d_c_max_idx", k), 32'(max_idx_c), 32'(sat7(vecs[k].umax_i)));
      check($sformatf("v%0d_c_count", k), 32'(count_c), 32'(sat7(vecs[k].cnt)));
      handshake();
    end

    // Idle input cycle inside a frame must not disturb the accumulation.
    beat(32'd6, 1'b0);
    @(negedge clk);
    in_data = 32'd1;
    in_last = 1'b1;
    @(posedge clk);
    #1;
    in_last = 1'b0;
    beat(32'd8, 1'b1);
    @(negedge clk);
    check("idle_min", min_u, 32'd6);
    check("idle_max", max_u, 32'd8);
    check("idle_count", 32'(count_u), 32'd2);
    handshake();

    // Output backpressure with a beat waiting upstream.
    beat(32'd11, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    in_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid_u), 32'd1);
      check("bp_in_ready", 32'(in_ready_u), 32'd0);
      check("bp_min", min_u, 32'd11);
      check("bp_count", 32'(count_u), 32'd1);
    end
    in_data   = 32'd42;
    in_last   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid_u), 32'd0);
    check("bp_release_ready", 32'(in_ready_u), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("bp_next_valid", 32'(out_valid_u), 32'd1);
    check("bp_next_max", max_u, 32'd42);
    check("bp_next_count", 32'(count_u), 32'd1);
    handshake();

    // Reset while a result is held: out_valid drops without a clock edge.
    beat(32'd3, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_hold_valid", 32'(out_valid_u), 32'd0);
    check("rst_hold_count", 32'(count_u), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-frame discards the partial frame.
    beat(32'd9, 1'b0);
    beat(32'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_count", 32'(count_u), 32'd0);
    check("rst_mid_valid", 32'(out_valid_u), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(32'd4, 1'b0);
    beat(32'd2, 1'b1);
    @(negedge clk);
    check("after_rst_min", min_u, 32'd2);
    check("after_rst_min_idx", 32'(min_idx_u), 32'd1);
    check("after_rst_max", max_u, 32'd4);
    check("after_rst_max_idx", 32'(max_idx_u), 32'd0);
    check("after_rst_count", 32'(count_u), 32'd2);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
